pattern_sweep_gen: RTL and testbench

Synthesizable exhaustive stimulus sequencer for lab benches and on-board self-test. It steps a WIDTH-bit input pattern through every code in a selectable order: binary up, binary down, Gray, or maximal-length LFSR. Each code is held for HOLD clock cycles. The DUT response is sampled once per code and folded into a rotating-XOR signature, so a whole truth-table sweep can be checked by comparing a single word.

---
 rtl/pattern_sweep_gen.sv | 154 +++++++++++++++
 tb/tb_pattern_sweep_gen.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sweep_gen.sv
// Exhaustive pattern sequencer (up/down/Gray/LFSR) with rotating-XOR response signature.
// Latency: pattern/idx/valid/busy update one edge after start; done one edge after sweep end.
// Backpressure: none; stimulus is free-running, stop aborts at the next edge.
module pattern_sweep_gen #(
    parameter int WIDTH  = 3,
    parameter int HOLD   = 10,
    parameter int RESP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic              loop,
    input  logic [RESP_W-1:0] resp,
    output logic [WIDTH-1:0]  pattern,
    output logic [WIDTH-1:0]  idx,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [RESP_W-1:0] sig
);
    localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);

    // Feedback tap masks, bit t-1 set for 1-indexed tap t.
    localparam logic [7:0] TAP_MASK =
        (WIDTH == 2) ? 8'b0000_0011 :
        (WIDTH == 3) ? 8'b0000_0110 :
        (WIDTH == 4) ? 8'b0000_1100 :
        (WIDTH == 5) ? 8'b0001_0100 :
        (WIDTH == 6) ? 8'b0011_0000 :
        (WIDTH == 7) ? 8'b0110_0000 :
                       8'b1011_1000;
    localparam logic [WIDTH-1:0] TAPS      = TAP_MASK[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LAST_BIN  = WIDTH'(2 ** WIDTH - 1);
    localparam logic [WIDTH-1:0] LAST_LFSR = WIDTH'(2 ** WIDTH - 2);

    localparam logic [1:0] M_UP   = 2'b00;
    localparam logic [1:0] M_DOWN = 2'b01;
    localparam logic [1:0] M_GRAY = 2'b10;
    localparam logic [1:0] M_LFSR = 2'b11;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [1:0]       mode_q;
    logic [HCW-1:0]   hold_cnt;

    logic [WIDTH-1:0]  idx_nxt;
    logic [WIDTH-1:0]  code_next;
    logic [WIDTH-1:0]  idx_last;
    logic [RESP_W-1:0] sig_rot;
    logic              last_hold;
    logic              sweep_end;
    logic              fb;

    function automatic logic [WIDTH-1:0] first_code(input logic [1:0] m);
        logic [WIDTH-1:0] c;
        case (m)
            M_DOWN:  c = '1;
            M_LFSR:  c = WIDTH'(1);
            default: c = '0;
        endcase
        return c;
    endfunction

    generate
        if (RESP_W == 1) begin : g_rot1
            assign sig_rot = sig;
        end else begin : g_rotn
            assign sig_rot = {sig[RESP_W-2:0], sig[RESP_W-1]};
        end
    endgenerate

    assign last_hold = (hold_cnt == HOLD_LAST);
    assign idx_nxt   = idx + 1'b1;
    assign fb        = ^(pattern & TAPS);
    assign sweep_end = last_hold && (idx == idx_last);

    always_comb begin
        code_next = idx_nxt;
        idx_last  = LAST_BIN;
        case (mode_q)
            M_DOWN: code_next = pattern - 1'b1;
            M_GRAY: code_next = idx_nxt ^ (idx_nxt >> 1);
            M_LFSR: begin
                code_next = {pattern[WIDTH-2:0], fb};
                idx_last  = LAST_LFSR;
            end
            default: code_next = idx_nxt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= M_UP;
            hold_cnt <= '0;
            pattern  <= '0;
            idx      <= '0;
            sig      <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            valid <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        mode_q   <= mode;
                        pattern  <= first_code(mode);
                        idx      <= '0;
                        sig      <= '0;
                        hold_cnt <= '0;
                        valid    <= 1'b1;
                    end
                end
                RUN: begin
                    // The final-cycle sample is folded even when stop aborts that cycle.
                    if (last_hold) begin
                        sig <= sig_rot ^ resp;
                    end
                    if (stop) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                    end else if (!last_hold) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        hold_cnt <= '0;
                        if (!sweep_end) begin
                            pattern <= code_next;
                            idx     <= idx_nxt;
                            valid   <= 1'b1;
                        end else if (loop) begin
                            pattern <= first_code(mode_q);
                            idx     <= '0;
                            sig     <= '0;
                            valid   <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_sweep_gen.sv
// Bench for pattern_sweep_gen: three instances (HOLD 10, 1, 2) checked against a sequence/signature model.
module tb_pattern_sweep_gen;
    localparam int W  = 3;
    localparam int RW = 3;

    logic clk = 1'b0;
    logic rst, stop, loop;
    logic [1:0] mode;
    logic go [3];
    logic [W-1:0]  pat   [3];
    logic [W-1:0]  idx_o [3];
    logic [RW-1:0] sg    [3];
    logic [RW-1:0] rsp   [3];
    logic vld [3];
    logic bsy [3];
    logic dn  [3];
    logic [RW-1:0] lut [8];
    logic [RW-1:0] msig;
    int n_tests = 0;
    int n_fail  = 0;
    int lfsr_seq [7] = '{1, 2, 5, 3, 7, 6, 4};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign rsp[g] = lut[pat[g]];
        pattern_sweep_gen #(
            .WIDTH(W), .HOLD(g == 0 ? 10 : (g == 1 ? 1 : 2)), .RESP_W(RW)
        ) dut (
            .clk(clk), .rst(rst), .start(go[g]), .stop(stop), .mode(mode), .loop(loop),
            .resp(rsp[g]), .pattern(pat[g]), .idx(idx_o[g]), .valid(vld[g]),
            .busy(bsy[g]), .done(dn[g]), .sig(sg[g])
        );
    end

    function automatic int hold_of(input int s);
        return (s == 0) ? 10 : ((s == 1) ? 1 : 2);
    endfunction

    function automatic int len_of(input logic [1:0] m);
        return (m == 2'b11) ? 7 : 8;
    endfunction

    function automatic logic [W-1:0] code_of(input logic [1:0] m, input int i);
        case (m)
            2'b00:   return W'(i);
            2'b01:   return W'(7 - i);
            2'b10:   return W'(i ^ (i >> 1));
            default: return W'(lfsr_seq[i]);
        endcase
    endfunction

    function automatic logic [RW-1:0] fold(input logic [RW-1:0] s, input logic [RW-1:0] r);
        int v;
        v = int'(s);
        v = ((v << 1) | (v >> (RW - 1))) & ((1 << RW) - 1);
        return RW'(v) ^ r;
    endfunction

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic set_lut(input bit identity);
        for (int j = 0; j < 8; j++) lut[j] = identity ? RW'(j) : RW'($urandom);
    endtask

    task automatic do_start(input int s, input logic [1:0] m, input logic lp);
        mode = m;
        loop = lp;
        go[s] = 1'b1;
        cyc;
        go[s] = 1'b0;
        msig = '0;
        n_tests++;
        if (sg[s] !== '0) begin
            n_fail++;
            $display("FAIL start_sig_clear s=%0d: sig=%b, want 000", s, sg[s]);
        end
    endtask

    // Steps through n codes from index 0, checking every cycle and folding the model signature.
    task automatic walk(input int s, input logic [1:0] m, input int n, input bit disturb);
        for (int i = 0; i < n; i++) begin
            for (int h = 0; h < hold_of(s); h++) begin
                n_tests++;
                if (pat[s] !== code_of(m, i) || idx_o[s] !== W'(i) || vld[s] !== (h == 0) ||
                    bsy[s] !== 1'b1 || dn[s] !== 1'b0 || pat[s] === '0 && m == 2'b11) begin
                    n_fail++;
                    $display("FAIL walk s=%0d code %0d hold %0d: pattern=%b idx=%0d valid=%b busy=%b done=%b, want pattern=%b idx=%0d valid=%b busy=1 done=0",
                             s, i, h, pat[s], idx_o[s], vld[s], bsy[s], dn[s], code_of(m, i), i, (h == 0));
                end
                if (h == hold_of(s) - 1) msig = fold(msig, lut[code_of(m, i)]);
                if (disturb) begin
                    go[s] = 1'($urandom);
                    mode  = 2'($urandom);
                end
                cyc;
            end
        end
        if (disturb) go[s] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int s = 0; s < 3; s++) go[s] = 1'b1;
        mode = 2'b01;
        cyc;
        cyc;
        for (int s = 0; s < 3; s++) begin
            n_tests++;
            if (pat[s] !== '0 || idx_o[s] !== '0 || sg[s] !== '0 || vld[s] !== 1'b0 ||
                bsy[s] !== 1'b0 || dn[s] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset s=%0d: pattern=%b idx=%0d sig=%b valid=%b busy=%b done=%b, want all 0",
                         s, pat[s], idx_o[s], sg[s], vld[s], bsy[s], dn[s]);
            end
            go[s] = 1'b0;
        end
        rst = 1'b0;
        cyc;
    endtask

    task automatic test_up_sweep;
        set_lut(1'b1);
        do_start(0, 2'b00, 1'b0);
        walk(0, 2'b00, 8, 1'b0);
        n_tests++;
        if (dn[0] !== 1'b1 || bsy[0] !== 1'b0 || vld[0] !== 1'b0 || sg[0] !== msig || pat[0] !== 3'd7) begin
            n_fail++;
            $display("FAIL up_end: done=%b busy=%b valid=%b sig=%b pattern=%b, want 1 0 0 %b 111",
                     dn[0], bsy[0], vld[0], sg[0], pat[0], msig);
        end
        cyc;
        n_tests++;
        if (dn[0] !== 1'b0 || bsy[0] !== 1'b0 || sg[0] !== msig || pat[0] !== 3'd7 || idx_o[0] !== 3'd7) begin
            n_fail++;
            $display("FAIL up_idle_hold: done=%b busy=%b sig=%b pattern=%b idx=%0d, want 0 0 %b 111 7",
                     dn[0], bsy[0], sg[0], pat[0], idx_o[0], msig);
        end
    endtask

    task automatic test_lfsr;
        set_lut(1'b0);
        do_start(1, 2'b11, 1'b0);
        walk(1, 2'b11, 7, 1'b0);
        n_tests++;
        if (dn[1] !== 1'b1 || bsy[1] !== 1'b0 || sg[1] !== msig || pat[1] !== 3'b100 || idx_o[1] !== 3'd6) begin
            n_fail++;
            $display("FAIL lfsr_end: done=%b busy=%b sig=%b pattern=%b idx=%0d, want 1 0 %b 100 6",
                     dn[1], bsy[1], sg[1], pat[1], idx_o[1], msig);
        end
        cyc;
    endtask

    task automatic test_gray_loop;
        set_lut(1'b0);
        do_start(2, 2'b10, 1'b1);
        walk(2, 2'b10, 8, 1'b0);
        n_tests++;
        if (pat[2] !== 3'b000 || idx_o[2] !== 3'd0 || vld[2] !== 1'b1 || sg[2] !== '0 ||
            bsy[2] !== 1'b1 || dn[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL gray_wrap: pattern=%b idx=%0d valid=%b sig=%b busy=%b done=%b, want 000 0 1 000 1 0",
                     pat[2], idx_o[2], vld[2], sg[2], bsy[2], dn[2]);
        end
        msig = '0;
        loop = 1'b0;
        walk(2, 2'b10, 8, 1'b0);
        n_tests++;
        if (dn[2] !== 1'b1 || bsy[2] !== 1'b0 || sg[2] !== msig || pat[2] !== 3'b100) begin
            n_fail++;
            $display("FAIL gray_second_end: done=%b busy=%b sig=%b pattern=%b, want 1 0 %b 100",
                     dn[2], bsy[2], sg[2], pat[2], msig);
        end
        cyc;
    endtask

    task automatic test_stop;
        int h;
        for (int t = 0; t < 2; t++) begin
            h = (t == 0) ? 9 : int'($urandom_range(0, 8));
            set_lut(1'b0);
            do_start(0, 2'b01, 1'b0);
            walk(0, 2'b01, 3, 1'b0);
            repeat (h) cyc;
            n_tests++;
            if (pat[0] !== 3'd4 || idx_o[0] !== 3'd3 || bsy[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL stop_pre h=%0d: pattern=%0d idx=%0d busy=%b, want 4 3 1", h, pat[0], idx_o[0], bsy[0]);
            end
            stop = 1'b1;
            go[0] = 1'b1;
            cyc;
            stop = 1'b0;
            go[0] = 1'b0;
            if (h == 9) msig = fold(msig, lut[4]);
            n_tests++;
            if (bsy[0] !== 1'b0 || dn[0] !== 1'b0 || vld[0] !== 1'b0 || pat[0] !== 3'd4 ||
                idx_o[0] !== 3'd3 || sg[0] !== msig) begin
                n_fail++;
                $display("FAIL stop_post h=%0d: busy=%b done=%b valid=%b pattern=%0d idx=%0d sig=%b, want 0 0 0 4 3 %b",
                         h, bsy[0], dn[0], vld[0], pat[0], idx_o[0], sg[0], msig);
            end
            repeat (3) cyc;
            n_tests++;
            if (bsy[0] !== 1'b0 || dn[0] !== 1'b0 || pat[0] !== 3'd4 || sg[0] !== msig) begin
                n_fail++;
                $display("FAIL stop_idle h=%0d: busy=%b done=%b pattern=%0d sig=%b, want 0 0 4 %b",
                         h, bsy[0], dn[0], pat[0], sg[0], msig);
            end
        end
    endtask

    task automatic test_stop_last;
        set_lut(1'b0);
        do_start(1, 2'b00, 1'b0);
        walk(1, 2'b00, 7, 1'b0);
        stop = 1'b1;
        cyc;
        stop = 1'b0;
        msig = fold(msig, lut[7]);
        n_tests++;
        if (dn[1] !== 1'b0 || bsy[1] !== 1'b0 || sg[1] !== msig || pat[1] !== 3'd7) begin
            n_fail++;
            $display("FAIL stop_last: done=%b busy=%b sig=%b pattern=%0d, want 0 0 %b 7",
                     dn[1], bsy[1], sg[1], pat[1], msig);
        end
        cyc;
        n_tests++;
        if (dn[1] !== 1'b0 || bsy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_last_after: done=%b busy=%b, want 0 0", dn[1], bsy[1]);
        end
    endtask

    task automatic test_rst_mid;
        logic [1:0] m;
        m = 2'($urandom_range(0, 2));
        set_lut(1'b0);
        do_start(0, m, 1'b0);
        walk(0, m, 5, 1'b0);
        repeat ($urandom_range(0, 9)) cyc;
        rst = 1'b1;
        go[0] = 1'b1;
        cyc;
        n_tests++;
        if (pat[0] !== '0 || idx_o[0] !== '0 || sg[0] !== '0 || vld[0] !== 1'b0 ||
            bsy[0] !== 1'b0 || dn[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: pattern=%b idx=%0d sig=%b valid=%b busy=%b done=%b, want all 0",
                     pat[0], idx_o[0], sg[0], vld[0], bsy[0], dn[0]);
        end
        rst = 1'b0;
        go[0] = 1'b0;
        cyc;
        m = 2'($urandom);
        do_start(0, m, 1'b0);
        walk(0, m, len_of(m), 1'b0);
        n_tests++;
        if (dn[0] !== 1'b1 || bsy[0] !== 1'b0 || sg[0] !== msig) begin
            n_fail++;
            $display("FAIL rst_restart_end: done=%b busy=%b sig=%b, want 1 0 %b", dn[0], bsy[0], sg[0], msig);
        end
        cyc;
    endtask

    task automatic test_disturb;
        logic [1:0] m;
        for (int t = 0; t < 3; t++) begin
            m = 2'($urandom);
            set_lut(1'b0);
            do_start(2, m, 1'b0);
            walk(2, m, len_of(m), 1'b1);
            n_tests++;
            if (dn[2] !== 1'b1 || bsy[2] !== 1'b0 || sg[2] !== msig || pat[2] !== code_of(m, len_of(m) - 1)) begin
                n_fail++;
                $display("FAIL disturb_end mode=%0d: done=%b busy=%b sig=%b pattern=%b, want 1 0 %b %b",
                         m, dn[2], bsy[2], sg[2], pat[2], msig, code_of(m, len_of(m) - 1));
            end
            cyc;
            n_tests++;
            if (dn[2] !== 1'b0 || bsy[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL disturb_idle mode=%0d: done=%b busy=%b, want 0 0", m, dn[2], bsy[2]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        stop = 1'b0;
        loop = 1'b0;
        mode = 2'b00;
        for (int s = 0; s < 3; s++) go[s] = 1'b0;
        set_lut(1'b1);
        msig = '0;
        test_reset;
        test_up_sweep;
        test_lfsr;
        test_gray_loop;
        test_stop;
        test_stop_last;
        test_rst_mid;
        test_disturb;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
